// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_e;

    // Requester indices as seen on the owner output
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Read-wait counter holds READ_LAT-1, so it must cover 0..READ_LAT_MAX-1
    localparam int READ_LAT_MAX = 4;
    localparam int CNT_W        = $clog2(READ_LAT_MAX);

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: fixed priority to port 0 or round-robin with a port-1 lock.
// Latency: purely combinational.
// Backpressure: none; the caller only consults win when it can accept a grant.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    input  logic       fixed,
    output logic       win,
    output logic       any
);

    // Single requester wins outright; a tie goes to port 0 (fixed) or away from last (rr),
    // except that a locked port 1 that won last keeps the bus for its burst
    always_comb begin
        any = |req;
        win = last;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11: begin
                if (fixed) begin
                    win = 1'b0;
                end else if (lock && last) begin
                    win = 1'b1;
                end else begin
                    win = ~last;
                end
            end
            default: win = last;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (port 0) and debug (port 1) accesses onto one synchronous-read block RAM.
// Latency: gnt 1 cycle after req is sampled in IDLE; rvalid READ_LAT+2 cycles after sampling.
// Backpressure: requesters hold req until their gnt pulse; req is ignored while busy.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    input  logic              p1_lock,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    state_e              state_q,  state_d;
    logic                owner_q,  owner_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                rvalid_q, rvalid_d;

    logic                pick_win;
    logic                pick_any;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;

    rr_pick2 u_pick (
        .req   ({p1_req, p0_req}),
        .last  (owner_q),
        .lock  (p1_lock),
        .fixed (FIXED_PRIO != 0),
        .win   (pick_win),
        .any   (pick_any)
    );

    // Access fields of whichever port currently owns the memory
    always_comb begin
        acc_we    = (owner_q == PORT_DBG) ? p1_we    : p0_we;
        acc_addr  = (owner_q == PORT_DBG) ? p1_addr  : p0_addr;
        acc_wdata = (owner_q == PORT_DBG) ? p1_wdata : p0_wdata;
    end

    // State register; owner resets to port 1 so port 0 wins the first round-robin tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= PORT_DBG;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state: arbitrate in IDLE, one ACCESS cycle, then count down the read latency
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_win;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (acc_we) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory strobes and grants decode ACCESS; rvalid follows the capture by one cycle
    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = mem_en & acc_we;
        mem_addr  = mem_en ? acc_addr  : '0;
        mem_wdata = mem_en ? acc_wdata : '0;
        p0_gnt    = mem_en & (owner_q == PORT_CPU);
        p1_gnt    = mem_en & (owner_q == PORT_DBG);
        p0_rvalid = rvalid_q & (owner_q == PORT_CPU);
        p1_rvalid = rvalid_q & (owner_q == PORT_DBG);
        busy      = (state_q != IDLE);
        owner     = owner_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance a is round-robin with READ_LAT=1, instance b is fixed-priority with READ_LAT=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;

    logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid;
    logic        a_mem_en, a_mem_we, a_busy, a_owner;
    logic [8:0]  a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata, a_rdata;

    logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid;
    logic        b_mem_en, b_mem_we, b_busy, b_owner;
    logic [8:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata, b_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_lock(p1_lock),
        .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
    );

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_lock(p1_lock),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
    );

    // Block RAM for instance a: one-cycle synchronous read
    logic [31:0] mem_a [0:511];
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
            else          a_mem_rdata       <= mem_a[a_mem_addr];
        end
    end

    // Block RAM for instance b: three-cycle read pipeline
    logic [31:0] mem_b [0:511];
    logic [31:0] b_pipe [0:2];
    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = b_pipe[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_win;
        int cnt;
        logic got;

        rst = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        p1_lock = 1'b0;

        // Reset held two cycles with p0_req high
        p0_req = 1'b1;
        tick();
        tick();
        chk("rst_busy",   a_busy, 1'b0);
        chk("rst_mem_en", a_mem_en, 1'b0);
        chk("rst_rdata",  a_rdata, 32'h0);
        chk("rst_owner",  a_owner, 1'b1);
        chk("rst_gnt",    a_p0_gnt, 1'b0);
        rst = 1'b1;
        chk("rel_gnt_c1", a_p0_gnt, 1'b0);
        tick();
        chk("rel_gnt_c2", a_p0_gnt, 1'b1);
        p0_req = 1'b0;
        tick();
        tick();
        chk("rel_rvalid", a_p0_rvalid, 1'b1);

        // CPU write 0x010 then read it back
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h010; p0_wdata = 32'hDEADBEEF;
        tick();
        chk("wr_gnt",   a_p0_gnt, 1'b1);
        chk("wr_p1gnt", a_p1_gnt, 1'b0);
        chk("wr_en",    a_mem_en, 1'b1);
        chk("wr_we",    a_mem_we, 1'b1);
        chk("wr_addr",  a_mem_addr, 32'h010);
        chk("wr_data",  a_mem_wdata, 32'hDEADBEEF);
        p0_req = 1'b0;
        tick();
        chk("wr_free", a_busy, 1'b0);
        p0_req = 1'b1; p0_we = 1'b0;
        tick();
        chk("rd_gnt", a_p0_gnt, 1'b1);
        chk("rd_we",  a_mem_we, 1'b0);
        p0_req = 1'b0;
        tick();
        chk("rd_early", a_p0_rvalid, 1'b0);
        tick();
        chk("rd_rvalid",   a_p0_rvalid, 1'b1);
        chk("rd_p1rvalid", a_p1_rvalid, 1'b0);
        chk("rd_rdata",    a_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_pulse", a_p0_rvalid, 1'b0);
        chk("rd_hold",  a_rdata, 32'hDEADBEEF);

        // Preload 0x002 via port 0 and 0x001 via port 1 (leaves owner = 1)
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h002; p0_wdata = 32'h22222222;
        tick();
        chk("pre0_gnt", a_p0_gnt, 1'b1);
        p0_req = 1'b0;
        tick();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h001; p1_wdata = 32'h11111111;
        tick();
        chk("pre1_gnt", a_p1_gnt, 1'b1);
        p1_req = 1'b0;
        tick();

        // Round-robin contention: both read continuously, grants alternate 0,1,0,1
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h001;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h002;
        for (int k = 0; k < 4; k++) begin
            exp_win = k % 2;
            tick();
            chk("rr_p0gnt", a_p0_gnt, (exp_win == 0));
            chk("rr_p1gnt", a_p1_gnt, (exp_win == 1));
            tick();
            tick();
            chk("rr_p0rv", a_p0_rvalid, (exp_win == 0));
            chk("rr_p1rv", a_p1_rvalid, (exp_win == 1));
            chk("rr_rdata", a_rdata, (exp_win == 0) ? 32'h11111111 : 32'h22222222);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        // Fixed priority on instance b: ten writes all go to port 0
        do_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h020; p0_wdata = 32'hA5A5A5A5;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h030; p1_wdata = 32'h5A5A5A5A;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("fp_p0gnt", b_p0_gnt, 1'b1);
            chk("fp_p1gnt", b_p1_gnt, 1'b0);
            tick();
        end
        chk("fp_owner0", b_owner, 1'b0);
        p0_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (b_p1_gnt) begin
                got = 1'b1;
                break;
            end
        end
        chk("fp_p1_served", got, 1'b1);
        chk("fp_owner1", b_owner, 1'b1);
        p1_req = 1'b0;
        tick();

        // Lock burst on instance a: port 1 keeps the bus while lock is set
        do_reset();
        p1_lock = 1'b1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h040; p0_wdata = 32'h00000040;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h041; p1_wdata = 32'h00000041;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lk_p1gnt", a_p1_gnt, 1'b1);
            chk("lk_p0gnt", a_p0_gnt, 1'b0);
            tick();
        end
        p1_lock = 1'b0;
        tick();
        chk("lk_rel_p0gnt", a_p0_gnt, 1'b1);
        chk("lk_rel_owner", a_owner, 1'b0);
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        // Reset during RDWAIT on instance b (READ_LAT=3)
        do_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h050; p0_wdata = 32'hCAFEF00D;
        tick();
        chk("mr_wgnt", b_p0_gnt, 1'b1);
        p0_req = 1'b0;
        tick();
        p0_req = 1'b1; p0_we = 1'b0;
        tick();
        chk("mr_rgnt", b_p0_gnt, 1'b1);
        p0_req = 1'b0;
        tick();
        chk("mr_busy", b_busy, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_idle",  b_busy, 1'b0);
        chk("mr_rdata", b_rdata, 32'h0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_p0_rvalid || b_p1_rvalid) cnt++;
        end
        chk("mr_no_rvalid", cnt, 0);
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h050;
        tick();
        chk("mr_p1gnt", b_p1_gnt, 1'b1);
        p1_req = 1'b0;
        cnt = 0;
        got = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (b_p1_rvalid) begin
                cnt = i;
                got = 1'b1;
                break;
            end
        end
        chk("mr_rv_seen", got, 1'b1);
        chk("mr_rv_lat",  cnt, 4);
        chk("mr_data",    b_rdata, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
